delay_counter: RTL and testbench
================================

# delay_counter

Timing engine for the processor's delay instruction and the counterpart of the program counter's `delay`/`count_done` stall handshake. When the decoder raises `delay`, the block captures the instruction's delay operand and counts that many prescaled ticks. It then pulses `count_done` for exactly one cycle, on which the program counter advances. This holds valve/pump outputs stable for a programmed interval in the microfluidic flow controller.

## Interface
Parameters:
- `PRESCALE`, default 100000: clk cycles per delay tick (1 ms at 100 MHz); must be ≥1.
- `DW`, default 16: width of the delay operand, in ticks.

Ports:
- `clk`, input, 1: sole clock; all logic updates on its rising edge.
- `rst`, input, 1: synchronous, active-low reset.
- `delay`, input, 1: high while the current instruction is a delay instruction.
- `delay_val`, input, DW: delay length in ticks; sampled only at request acceptance.
- `pchalt`, input, 1: halt; aborts any delay in progress.
- `count_done`, output, 1: registered one-cycle completion pulse to the program counter.
- `busy`, output, 1: high in COUNT and DONE.
- `remaining`, output, DW: ticks left in the current delay; 0 when idle.

## Operation
- Counters: `tick_cnt`, width clog2(PRESCALE) (min 1), range 0..PRESCALE-1; `remaining`, DW bits, unsigned.
- State machine: IDLE, COUNT, DONE. `count_done` = (state==DONE). `busy` = (state!=IDLE).
- IDLE:
  - `delay`=1, `pchalt`=0, `delay_val`≠0: load `remaining`←`delay_val`, `tick_cnt`←0, go COUNT.
  - `delay`=1, `pchalt`=0, `delay_val`=0: go DONE directly; `remaining` stays 0.
  - Otherwise: stay in IDLE.
- COUNT:
  - Each cycle, `tick_cnt` increments.
  - When `tick_cnt`==PRESCALE-1: `tick_cnt`←0 and `remaining` decrements.
  - If that decrement takes `remaining` from 1 to 0: go DONE.
- DONE: lasts exactly one cycle, then unconditionally IDLE.
- Abort: in COUNT, `pchalt`=1 or `delay`=0 forces IDLE next cycle. Clear `tick_cnt` and `remaining`. No `count_done` is produced.
- `pchalt` has priority over `delay` in every state. In DONE, `pchalt` still returns the block to IDLE; the pulse already issued is not retracted.
- `delay_val` changes during COUNT are ignored.
- Back-to-back delay instructions: `delay` still high in the IDLE cycle after DONE is a new request and is loaded with the new `delay_val`.
- `remaining` never wraps; it cannot decrement below 0.

## Timing
- Reset (`rst`=0 at a clock edge): state IDLE, `count_done`=0, `busy`=0, `remaining`=0, `tick_cnt`=0. Reset overrides all other inputs, including mid-COUNT.
- Request accepted at edge E0. For N≥1, `count_done` is high during the cycle after edge E0 + N·PRESCALE.
  - Program counter stall: the instruction occupies N·PRESCALE+2 cycles, including the IDLE accept cycle and the DONE cycle.
  - Consequence: the program counter sees `delay`=1 with `count_done`=0 for N·PRESCALE+1 cycles, then `count_done`=1 for one cycle, and increments on that edge.
- N=0: occupies 2 cycles (IDLE, then DONE).
- `count_done` is never high for two consecutive cycles.
- Minimum spacing between pulses: N·PRESCALE+2 cycles.

## Test plan
Benches use PRESCALE=4, DW=8.
- Reset: hold `rst`=0 for 3 cycles with `delay`=1 and `delay_val`=5. Required: `count_done`=0, `busy`=0, `remaining`=0 throughout; the request is accepted on the first edge after `rst`=1.
- Basic delay: `delay`=1, `delay_val`=3. Required: `remaining` reads 3, 2, 1, 0, stepping every 4 cycles after accept; a single `count_done` pulse 14 cycles after `delay` rises (3·4+2).
- Zero delay: `delay_val`=0. Required: `count_done` pulses in the second cycle of the instruction; `remaining` stays 0.
- Abort: `delay_val`=10, then `pchalt`=1 at cycle 7. Required: IDLE next cycle, `remaining`=0, no `count_done`. Repeat with `delay` dropped instead of `pchalt`; required response is identical.
- Back-to-back: `delay` held high; `delay_val`=2 for the first instruction, then 1 after the first pulse. Required: pulses at instruction cycles 10 and 10+6; `delay_val` changes during COUNT have no effect.
- Reset mid-count: `rst`=0 while `remaining`=4. Required: all outputs 0 the next cycle; no pulse.

Source files
------------

// File: rtl/delay_counter_if.sv
// Delay-instruction handshake between decoder/program counter and delay_counter.
// The master drives the request; the slave returns the completion pulse and status.
interface delay_counter_if #(
  parameter int DW = 16
);
  logic          delay;
  logic [DW-1:0] delay_val;
  logic          pchalt;
  logic          count_done;
  logic          busy;
  logic [DW-1:0] remaining;

  modport master (
    output delay, delay_val, pchalt,
    input  count_done, busy, remaining
  );

  modport slave (
    input  delay, delay_val, pchalt,
    output count_done, busy, remaining
  );
endinterface

// File: rtl/delay_counter.sv
// Counts delay_val ticks of PRESCALE clocks, then pulses count_done for one cycle.
// Latency N*PRESCALE+2 cycles per instruction; pchalt or a dropped delay aborts with no pulse.
module delay_counter #(
  parameter int PRESCALE = 100000,
  parameter int DW       = 16
) (
  input  logic           clk,
  input  logic           rst,
  delay_counter_if.slave bus
);

  localparam int            TW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [TW-1:0] r_tick_cnt;
  logic [DW-1:0] r_remaining;

  logic w_accept;
  logic w_abort;
  logic w_tick_wrap;
  logic w_last_tick;

  assign w_accept    = bus.delay && !bus.pchalt;
  assign w_abort     = bus.pchalt || !bus.delay;
  assign w_tick_wrap = (r_tick_cnt == TICK_MAX);
  assign w_last_tick = w_tick_wrap && (r_remaining == DW'(1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = (bus.delay_val == '0) ? S_DONE : S_COUNT;
        end
      end
      S_COUNT: begin
        if (w_abort) begin
          w_next = S_IDLE;
        end else if (w_last_tick) begin
          w_next = S_DONE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // A zero operand loads 0, so the IDLE load needs no separate zero-delay case.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tick_cnt  <= '0;
      r_remaining <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tick_cnt  <= '0;
          r_remaining <= w_accept ? bus.delay_val : '0;
        end
        S_COUNT: begin
          if (w_abort) begin
            r_tick_cnt  <= '0;
            r_remaining <= '0;
          end else if (w_tick_wrap) begin
            r_tick_cnt <= '0;
            if (r_remaining != '0) begin
              r_remaining <= r_remaining - DW'(1);
            end
          end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
          end
        end
        default: begin
          r_tick_cnt  <= '0;
          r_remaining <= '0;
        end
      endcase
    end
  end

  always_comb begin
    bus.count_done = (r_state == S_DONE);
    bus.busy       = (r_state != S_IDLE);
    bus.remaining  = r_remaining;
  end

endmodule

// File: tb/tb_delay_counter.sv
// Directed bench for delay_counter at PRESCALE=4, DW=8.
// Expected outputs are queued as each step is driven and compared after the edge.
module tb_delay_counter;

  localparam int P  = 4;
  localparam int DW = 8;

  typedef struct packed {
    logic          done;
    logic          busy;
    logic [DW-1:0] rem;
  } obs_t;

  logic clk;
  logic rst;
  delay_counter_if #(.DW(DW)) bus ();

  delay_counter #(.PRESCALE(P), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic obs_t mk(input bit d, input bit b, input int r);
    obs_t o;
    o.done = d;
    o.busy = b;
    o.rem  = DW'(r);
    return o;
  endfunction

  task automatic step(input bit r, input bit d, input logic [DW-1:0] v, input bit h,
                      input obs_t e, input string tag);
    obs_t got;
    obs_t want;
    @(negedge clk);
    rst           = r;
    bus.delay     = d;
    bus.delay_val = v;
    bus.pchalt    = h;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got  = {bus.count_done, bus.busy, bus.remaining};
    want = exp_q.pop_front();
    n_checks++;
    assert (got === want) n_pass++;
    else $error("FAIL %s: got done=%0b busy=%0b rem=%0d, want done=%0b busy=%0b rem=%0d",
                tag, got.done, got.busy, got.rem, want.done, want.busy, want.rem);
  endtask

  // Instruction cycle 1 is the accept cycle; abort_at names the cycle in which the abort is driven.
  task automatic run_delay(input int n, input int abort_at, input bit use_halt,
                           input bit hold, input string tag);
    step(1'b1, 1'b1, DW'(n), 1'b0, (n == 0) ? mk(1, 1, 0) : mk(0, 1, n),
         $sformatf("%s accept", tag));
    for (int k = 1; k <= n * P; k++) begin
      if (abort_at == k + 1) begin
        step(1'b1, use_halt, DW'($urandom_range(0, 255)), use_halt, mk(0, 0, 0),
             $sformatf("%s abort", tag));
        step(1'b1, 1'b0, '0, 1'b0, mk(0, 0, 0), $sformatf("%s post-abort1", tag));
        step(1'b1, 1'b0, '0, 1'b0, mk(0, 0, 0), $sformatf("%s post-abort2", tag));
        return;
      end
      step(1'b1, 1'b1, DW'($urandom_range(0, 255)), 1'b0,
           mk(k == n * P, 1, n - k / P), $sformatf("%s k=%0d", tag, k));
    end
    step(1'b1, hold, '0, 1'b0, mk(0, 0, 0), $sformatf("%s drain", tag));
  endtask

  initial begin
    rst           = 1'b0;
    bus.delay     = 1'b0;
    bus.delay_val = '0;
    bus.pchalt    = 1'b0;

    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, DW'(5), 1'b0, mk(0, 0, 0), $sformatf("reset%0d", i));
    end
    run_delay(5, 0, 1'b0, 1'b0, "post_reset");

    run_delay(3, 0, 1'b0, 1'b0, "basic");
    run_delay(0, 0, 1'b0, 1'b0, "zero");

    step(1'b1, 1'b1, DW'(5), 1'b1, mk(0, 0, 0), "idle_halt1");
    step(1'b1, 1'b1, DW'(0), 1'b1, mk(0, 0, 0), "idle_halt2");

    run_delay(10, 7, 1'b1, 1'b0, "abort_halt");
    run_delay(10, 7, 1'b0, 1'b0, "abort_drop");

    run_delay(2, 0, 1'b0, 1'b1, "b2b_first");
    run_delay(1, 0, 1'b0, 1'b0, "b2b_second");

    step(1'b1, 1'b1, DW'(6), 1'b0, mk(0, 1, 6), "rstmid accept");
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1'b1, DW'($urandom_range(0, 255)), 1'b0, mk(0, 1, 6 - k / P),
           $sformatf("rstmid k=%0d", k));
    end
    step(1'b0, 1'b1, DW'(6), 1'b0, mk(0, 0, 0), "rstmid reset");
    step(1'b1, 1'b0, '0, 1'b0, mk(0, 0, 0), "rstmid after1");
    step(1'b1, 1'b0, '0, 1'b0, mk(0, 0, 0), "rstmid after2");

    n_checks++;
    assert (exp_q.size() == 0) n_pass++;
    else $error("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
